// File: rtl/noc_router_multi_if.sv
`default_nettype none
// ============================================================================
// noc_router_multi_if : source flit port and per-channel output handshakes
// Revision 1.0
// ============================================================================
interface noc_router_multi_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3,
  parameter int TYPE_W = 2
);
  logic [TYPE_W+DATA_W:0]   packet;
  logic                     src_valid;
  logic                     src_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_eof;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;

  modport master (
    output packet, src_valid, out_ready,
    input  src_ready, out_data, out_eof, out_valid
  );

  modport slave (
    input  packet, src_valid, out_ready,
    output src_ready, out_data, out_eof, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/noc_router_multi.sv
`default_nettype none
// ============================================================================
// noc_router_multi : wormhole router, one flit source to NUM_CH FIFO'd channels
// Revision 1.0
// ============================================================================
module noc_router_multi #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 3,
  parameter int TYPE_W     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  noc_router_multi_if.slave bus,
  output logic [7:0]        drop_cnt,
  output logic              busy
);

  localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                 c_CNT_W     = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
  localparam logic [TYPE_W:0]    c_NUM_CH    = (TYPE_W+1)'(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t            r_state;
  logic [TYPE_W-1:0] r_lock_ch;
  logic [7:0]        r_drop_cnt;

  logic [TYPE_W-1:0] w_type;
  logic              w_eof;
  logic [DATA_W-1:0] w_data;
  logic              w_mapped;
  logic [TYPE_W-1:0] w_tgt;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_out_valid;
  logic [NUM_CH-1:0] w_out_eof;
  logic [NUM_CH*DATA_W-1:0] w_out_data;
  logic              w_tgt_full;
  logic              w_src_ready;
  logic              w_fire;
  logic              w_discard;

  assign {w_type, w_eof, w_data} = bus.packet;

  assign w_mapped = ({1'b0, w_type} < c_NUM_CH);
  // Body flits follow the locked channel; their own type field is ignored.
  assign w_tgt    = (r_state == ST_ROUTE) ? r_lock_ch : w_type;

  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c] = (w_tgt == TYPE_W'(c));
    end
  end

  assign w_tgt_full = |(w_sel & w_full);

  always_comb begin
    w_src_ready = 1'b0;
    if (rst) begin
      case (r_state)
        ST_IDLE:  w_src_ready = w_mapped ? !w_tgt_full : 1'b1;
        ST_ROUTE: w_src_ready = !w_tgt_full;
        ST_DROP:  w_src_ready = 1'b1;
        default:  w_src_ready = 1'b0;
      endcase
    end
  end

  assign w_discard = (r_state == ST_DROP) || ((r_state == ST_IDLE) && !w_mapped);
  assign w_fire    = bus.src_valid & w_src_ready;
  assign w_push    = (w_fire && !w_discard) ? w_sel : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_lock_ch  <= '0;
      r_drop_cnt <= '0;
    end else if (w_fire) begin
      case (r_state)
        ST_IDLE: begin
          if (w_mapped) begin
            if (!w_eof) begin
              r_state   <= ST_ROUTE;
              r_lock_ch <= w_type;
            end
          end else if (!w_eof) begin
            r_state <= ST_DROP;
          end else if (r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
          end
        end
        ST_ROUTE: begin
          if (w_eof) r_state <= ST_IDLE;
        end
        ST_DROP: begin
          if (w_eof) begin
            r_state <= ST_IDLE;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DATA_W:0]    r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_valid;
    logic               w_pop;
    logic [DATA_W:0]    w_head;

    assign w_valid = (r_cnt != '0);
    assign w_pop   = w_valid & bus.out_ready[g];
    // Empty channels present zeros so the outputs are clean after reset.
    assign w_head  = w_valid ? r_mem[r_rd_ptr] : '0;

    assign w_full[g]                       = (r_cnt == c_DEPTH_CNT);
    assign w_out_valid[g]                  = w_valid;
    assign w_out_eof[g]                    = w_head[DATA_W];
    assign w_out_data[g*DATA_W +: DATA_W]  = w_head[DATA_W-1:0];

    always_ff @(posedge clk) begin
      if (w_push[g]) r_mem[r_wr_ptr] <= {w_eof, w_data};
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push[g]) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push[g], w_pop})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  assign bus.src_ready = w_src_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_eof   = w_out_eof;
  assign bus.out_data  = w_out_data;
  assign drop_cnt      = r_drop_cnt;
  assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire
